// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between two writeback sources:
//   A (in-order ALU pipeline) and B (long-latency load/mul/div unit). Keeps a
//   pending-write scoreboard of B destinations and raises an issue stall on
//   RAW/WAW hazards against in-flight B operations.
//
//   Optional feature macro: WB_RR_EN
//     defined   : round-robin arbitration on a tie (A wins the first tie after reset)
//     undefined : fixed priority, B beats A on a tie
//
// Ports
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   a_valid_i/a_index_i/a_data_i, a_ready_o   source A write request / grant
//   b_valid_i/b_index_i/b_data_i, b_ready_o   source B write request / grant
//   iss_valid_i, iss_long_i, iss_rd_en_i, iss_rd_index_i,
//   rs1_index_i, rs2_index_i, iss_stall_o     issue-stage hazard check
//   rd_en_o, rd_index_o, rd_data_o            registered regfile write port
//   pending_o                                 scoreboard bitmap (bit 0 always 0)
//   conflict_cnt_o                            saturating count of tie cycles
module wb_port_arbiter #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               a_valid_i,
  input  logic [IDX_W-1:0]   a_index_i,
  input  logic [XLEN-1:0]    a_data_i,
  output logic               a_ready_o,
  input  logic               b_valid_i,
  input  logic [IDX_W-1:0]   b_index_i,
  input  logic [XLEN-1:0]    b_data_i,
  output logic               b_ready_o,
  input  logic               iss_valid_i,
  input  logic               iss_long_i,
  input  logic               iss_rd_en_i,
  input  logic [IDX_W-1:0]   iss_rd_index_i,
  input  logic [IDX_W-1:0]   rs1_index_i,
  input  logic [IDX_W-1:0]   rs2_index_i,
  output logic               iss_stall_o,
  output logic               rd_en_o,
  output logic [IDX_W-1:0]   rd_index_o,
  output logic [XLEN-1:0]    rd_data_o,
  output logic [REG_NUM-1:0] pending_o,
  output logic [CNT_W-1:0]   conflict_cnt_o
);

  logic               tie;
  logic               a_wins_tie;
  logic               grant_a;
  logic               grant_b;
  logic               rd_en_d, rd_en_q;
  logic [IDX_W-1:0]   rd_index_d, rd_index_q;
  logic [XLEN-1:0]    rd_data_d, rd_data_q;
  logic [REG_NUM-1:0] pending_d, pending_q;
  logic [REG_NUM-1:0] set_mask, clr_mask;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               stall;

  assign tie = a_valid_i & b_valid_i;

`ifdef WB_RR_EN
  // 1 = B was granted last; reset to B so A takes the first tie.
  logic last_b_d, last_b_q;

  assign a_wins_tie = last_b_q;

  always_comb begin
    last_b_d = last_b_q;
    if (grant_b) begin
      last_b_d = 1'b1;
    end else if (grant_a) begin
      last_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  assign a_wins_tie = 1'b0;
`endif

  // Grants are combinational and forced low while reset is asserted.
  assign grant_a = rst_ni & a_valid_i & (~b_valid_i | a_wins_tie);
  assign grant_b = rst_ni & b_valid_i & (~a_valid_i | ~a_wins_tie);

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  // No bypass: a bit being cleared this cycle still stalls this cycle.
  assign stall = iss_valid_i & (pending_q[rs1_index_i] | pending_q[rs2_index_i] |
                                (iss_rd_en_i & pending_q[iss_rd_index_i]));
  assign iss_stall_o = stall;

  // Write-port next state; index 0 completes the handshake but never writes.
  always_comb begin
    rd_en_d    = 1'b0;
    rd_index_d = rd_index_q;
    rd_data_d  = rd_data_q;
    if (grant_a) begin
      rd_en_d    = |a_index_i;
      rd_index_d = a_index_i;
      rd_data_d  = a_data_i;
    end else if (grant_b) begin
      rd_en_d    = |b_index_i;
      rd_index_d = b_index_i;
      rd_data_d  = b_data_i;
    end
  end

  // Scoreboard: set applied after clear so a same-index new op wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant_b && (b_index_i != '0)) begin
      clr_mask[b_index_i] = 1'b1;
    end
    if (iss_valid_i && iss_long_i && iss_rd_en_i && !stall && (iss_rd_index_i != '0)) begin
      set_mask[iss_rd_index_i] = 1'b1;
    end
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (tie && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q    <= 1'b0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_en_o        = rd_en_q;
  assign rd_index_o     = rd_index_q;
  assign rd_data_o      = rd_data_q;
  assign pending_o      = pending_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the port rules.
module tb_wb_port_arbiter;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic               clk;
  logic               rst_n;
  logic               a_valid, b_valid, a_ready, b_ready;
  logic [IDX_W-1:0]   a_index, b_index;
  logic [XLEN-1:0]    a_data, b_data;
  logic               iss_valid, iss_long, iss_rd_en, iss_stall;
  logic [IDX_W-1:0]   iss_rd, rs1, rs2;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_index;
  logic [XLEN-1:0]    rd_data;
  logic [REG_NUM-1:0] pending;
  logic [CNT_W-1:0]   conflict_cnt;

  wb_port_arbiter #(
    .XLEN    (XLEN),
    .IDX_W   (IDX_W),
    .REG_NUM (REG_NUM),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .a_valid_i      (a_valid),
    .a_index_i      (a_index),
    .a_data_i       (a_data),
    .a_ready_o      (a_ready),
    .b_valid_i      (b_valid),
    .b_index_i      (b_index),
    .b_data_i       (b_data),
    .b_ready_o      (b_ready),
    .iss_valid_i    (iss_valid),
    .iss_long_i     (iss_long),
    .iss_rd_en_i    (iss_rd_en),
    .iss_rd_index_i (iss_rd),
    .rs1_index_i    (rs1),
    .rs2_index_i    (rs2),
    .iss_stall_o    (iss_stall),
    .rd_en_o        (rd_en),
    .rd_index_o     (rd_index),
    .rd_data_o      (rd_data),
    .pending_o      (pending),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state
  logic [REG_NUM-1:0] m_pend;
  bit                 m_last_b;
  int                 m_cnt;
  bit                 m_rd_en;
  logic [IDX_W-1:0]   m_rd_idx;
  logic [XLEN-1:0]    m_rd_data;
  bit                 last_ga, last_gb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend    = '0;
    m_last_b  = 1'b1;
    m_cnt     = 0;
    m_rd_en   = 1'b0;
    m_rd_idx  = '0;
    m_rd_data = '0;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_index = '0; a_data = '0;
    b_valid = 0; b_index = '0; b_data = '0;
    iss_valid = 0; iss_long = 0; iss_rd_en = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, "_rd_index"}, 64'(rd_index), 64'd0);
    chk({tag, "_rd_data"}, rd_data, 64'd0);
    chk({tag, "_pending"}, 64'(pending), 64'd0);
    chk({tag, "_cnt"}, 64'(conflict_cnt), 64'd0);
    chk({tag, "_a_ready"}, 64'(a_ready), 64'd0);
    chk({tag, "_b_ready"}, 64'(b_ready), 64'd0);
  endtask

  // One clock: called at posedge+1 with inputs driven; checks combinational
  // outputs mid-cycle, then registered outputs just after the next edge.
  task automatic cycle();
    bit ga, gb, st, tie;
    logic [REG_NUM-1:0] np;
    #3;
    tie = a_valid && b_valid;
    if (tie) begin
`ifdef WB_RR_EN
      ga = m_last_b;
`else
      ga = 1'b0;
`endif
      gb = !ga;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
    st = iss_valid && (m_pend[rs1] || m_pend[rs2] || (iss_rd_en && m_pend[iss_rd]));
    chk("a_ready", 64'(a_ready), 64'(ga));
    chk("b_ready", 64'(b_ready), 64'(gb));
    chk("iss_stall", 64'(iss_stall), 64'(st));
    last_ga = ga;
    last_gb = gb;
    np = m_pend;
    if (gb && b_index != 0) np[b_index] = 1'b0;
    if (iss_valid && iss_long && iss_rd_en && !st && iss_rd != 0) np[iss_rd] = 1'b1;
    m_pend  = np;
    m_rd_en = 1'b0;
    if (ga) begin
      m_rd_en = (a_index != 0); m_rd_idx = a_index; m_rd_data = a_data;
    end else if (gb) begin
      m_rd_en = (b_index != 0); m_rd_idx = b_index; m_rd_data = b_data;
    end
    if (tie && m_cnt < CNT_MAX) m_cnt++;
    if (ga || gb) m_last_b = gb;
    @(posedge clk);
    #1;
    chk("rd_en", 64'(rd_en), 64'(m_rd_en));
    if (m_rd_en) begin
      chk("rd_index", 64'(rd_index), 64'(m_rd_idx));
      chk("rd_data", rd_data, m_rd_data);
    end
    chk("pending", 64'(pending), 64'(m_pend));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    last_ga = 0;
    last_gb = 0;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    a_valid = 1'b1;
    a_index = 5'd3;
    #12;
    chk_all_zero("reset");
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: lone A write, registered one cycle later
    a_valid = 1; a_index = 5'd5; a_data = 64'h11;
    cycle();
    chk("t1_rd_data", rd_data, 64'h11);
    idle_inputs();
    cycle();

    // 2: four-cycle tie
    a_valid = 1; a_index = 5'd4; a_data = 64'hAAAA;
    b_valid = 1; b_index = 5'd3; b_data = 64'hBBBB;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (last_ga) begin
        a_data = a_data + 1;
      end
      if (last_gb) begin
        b_data = b_data + 1;
      end
    end
    chk("t2_cnt", 64'(conflict_cnt), 64'd4);
    idle_inputs();
    cycle();

    // 3: long op rd=7 then dependent issue stalls until B writes back x7
    iss_valid = 1; iss_long = 1; iss_rd_en = 1; iss_rd = 5'd7;
    cycle();
    chk("t3_pend7_set", 64'(pending[7]), 64'd1);
    iss_long = 0; iss_rd = 5'd9; rs1 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      cycle();
    end
    b_valid = 1; b_index = 5'd7; b_data = 64'h7777;
    cycle();
    b_valid = 0;
    cycle();
    chk("t3_stall_drop", 64'(iss_stall), 64'd0);
    chk("t3_pend7_clr", 64'(pending[7]), 64'd0);

    // 4: B clears x7 in the same cycle a new long op targets x7
    iss_long = 1; iss_rd = 5'd7; rs1 = 5'd0;
    b_valid = 1; b_index = 5'd7; b_data = 64'h7878;
    cycle();
    chk("t4_pend7", 64'(pending[7]), 64'd1);
    idle_inputs();

    // 5: index 0 never writes and never enters the scoreboard
    a_valid = 1; a_index = 5'd0; a_data = 64'h55;
    iss_valid = 1; iss_long = 1; iss_rd_en = 1; iss_rd = 5'd0;
    cycle();
    chk("t5_rd_en", 64'(rd_en), 64'd0);
    idle_inputs();

    // 6a: asynchronous reset mid-cycle with a pending bit and a live write
    a_valid = 1; a_index = 5'd3; a_data = 64'h33;
    cycle();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 6b: counter saturation under a permanent tie
    a_valid = 1; a_index = 5'd0; b_valid = 1; b_index = 5'd0;
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      cycle();
    end
    chk("t6_sat", 64'(conflict_cnt), 64'hFFFF);
    idle_inputs();
    cycle();

    // Randomized traffic; requests held until granted
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || last_ga) begin
        a_valid = 1'($urandom_range(0, 1));
        a_index = 5'($urandom_range(0, 7));
        a_data  = {$urandom, $urandom};
      end
      if (!b_valid || last_gb) begin
        b_valid = 1'($urandom_range(0, 1));
        b_index = 5'($urandom_range(0, 7));
        b_data  = {$urandom, $urandom};
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_long  = 1'($urandom_range(0, 1));
      iss_rd_en = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
